// File: rtl/audio_mixer_pkg.sv
`default_nettype none
// ============================================================================
// audio_mixer_pkg : shared gain constants and mixer FSM state encoding
// Revision 1.0
// ============================================================================
package audio_mixer_pkg;

    localparam int unsigned GAIN_WIDTH = 4;
    localparam int unsigned GAIN_UNITY = 8;
    localparam int unsigned GAIN_SHIFT = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SNAP = 2'd1,
        ACC  = 2'd2,
        SAT  = 2'd3
    } mix_state_t;

endpackage
`default_nettype wire

// File: rtl/audio_mixer_if.sv
`default_nettype none
// ============================================================================
// audio_mixer_if : card-source inputs and mixed-sample outputs of the mixer
// Revision 1.0
// ============================================================================
interface audio_mixer_if #(
    parameter int unsigned NUM_SRC   = 2,
    parameter int unsigned SRC_WIDTH = 10,
    parameter int unsigned OUT_WIDTH = 16
);
    import audio_mixer_pkg::*;

    logic                            speaker_bit_i;
    logic [NUM_SRC*SRC_WIDTH-1:0]    src_l_i;
    logic [NUM_SRC*SRC_WIDTH-1:0]    src_r_i;
    logic [NUM_SRC*GAIN_WIDTH-1:0]   src_gain_i;
    logic                            mute_i;
    logic                            clk_audio_o;
    logic [OUT_WIDTH-1:0]            sample_l_o;
    logic [OUT_WIDTH-1:0]            sample_r_o;
    logic                            sample_valid_o;

    // Card / stimulus side
    modport master (
        output speaker_bit_i, src_l_i, src_r_i, src_gain_i, mute_i,
        input  clk_audio_o, sample_l_o, sample_r_o, sample_valid_o
    );

    // Mixer side
    modport slave (
        input  speaker_bit_i, src_l_i, src_r_i, src_gain_i, mute_i,
        output clk_audio_o, sample_l_o, sample_r_o, sample_valid_o
    );

endinterface
`default_nettype wire

// File: rtl/audio_mixer_speaker_pulse.sv
`default_nettype none
// ============================================================================
// audio_mixer_speaker_pulse : turns the Apple speaker toggle into a bounded pulse
// Revision 1.0
// ============================================================================
module audio_mixer_speaker_pulse #(
    parameter int unsigned SPEAKER_HOLD   = 255,
    parameter int unsigned SPEAKER_ENABLE = 1
) (
    input  logic clk_pixel_w,
    input  logic system_reset_n_w,
    input  logic tick,
    input  logic speaker_bit,
    output logic spk_on
);

    localparam int unsigned CTR_W = (SPEAKER_HOLD > 0) ? $clog2(SPEAKER_HOLD + 1) : 1;

    logic             sync_meta;
    logic             sync_bit;
    logic             prev;
    logic [CTR_W-1:0] ctr;

    always_ff @(posedge clk_pixel_w or negedge system_reset_n_w) begin
        if (!system_reset_n_w) begin
            sync_meta <= 1'b0;
            sync_bit  <= 1'b0;
            prev      <= 1'b0;
            ctr       <= '0;
        end else begin
            sync_meta <= speaker_bit;
            sync_bit  <= sync_meta;
            // Edges are only looked at once per output sample
            if (tick) begin
                if (sync_bit != prev) begin
                    ctr <= CTR_W'(SPEAKER_HOLD);
                end else if (ctr != '0) begin
                    ctr <= ctr - CTR_W'(1);
                end
                prev <= sync_bit;
            end
        end
    end

    assign spk_on = (SPEAKER_ENABLE != 0) && prev && (ctr != '0);

endmodule
`default_nettype wire

// File: rtl/audio_mixer.sv
`default_nettype none
// ============================================================================
// audio_mixer : N-source stereo mixer with per-source gain, speaker pulse,
//               saturation and HDMI audio sample-rate generation. Revision 1.0
// ============================================================================
module audio_mixer
    import audio_mixer_pkg::*;
#(
    parameter int unsigned PIXEL_CLK_HZ   = 27_000_000,
    parameter int unsigned AUDIO_RATE     = 44_100,
    parameter int unsigned NUM_SRC        = 2,
    parameter int unsigned SRC_WIDTH      = 10,
    parameter int unsigned OUT_WIDTH      = 16,
    parameter int unsigned SPEAKER_ENABLE = 1,
    parameter int unsigned SPEAKER_HOLD   = 255,
    parameter int unsigned SPEAKER_LEVEL  = 32'h2000
) (
    input  logic         clk_pixel_w,
    input  logic         system_reset_n_w,
    audio_mixer_if.slave bus
);

    localparam int unsigned DIV        = PIXEL_CLK_HZ / AUDIO_RATE;
    localparam int unsigned CNT_W      = $clog2(DIV);
    localparam int unsigned ACC_W      = OUT_WIDTH + $clog2(NUM_SRC + 1) + 1;
    localparam int unsigned TERM_SHIFT = OUT_WIDTH - 2 - SRC_WIDTH;
    localparam int unsigned IDX_W      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    // The whole mix must finish before clk_audio_o rises in the same period
    if (NUM_SRC + 3 >= DIV / 2) begin : g_bad_latency
        $error("audio_mixer: NUM_SRC too large for the sample divider");
    end
    if (SRC_WIDTH + 2 > OUT_WIDTH) begin : g_bad_width
        $error("audio_mixer: OUT_WIDTH must be at least SRC_WIDTH+2");
    end
    if (GAIN_UNITY != (1 << GAIN_SHIFT)) begin : g_bad_gain
        $error("audio_mixer: unity gain must equal 1 << GAIN_SHIFT");
    end

    logic [CNT_W-1:0]      cnt;
    logic                  tick;
    logic                  spk_on;
    mix_state_t            state;
    mix_state_t            next_state;
    logic [SRC_WIDTH-1:0]  snap_l    [NUM_SRC];
    logic [SRC_WIDTH-1:0]  snap_r    [NUM_SRC];
    logic [GAIN_WIDTH-1:0] snap_gain [NUM_SRC];
    logic                  snap_mute;
    logic                  snap_spk;
    logic [IDX_W-1:0]      idx;
    logic [ACC_W-1:0]      acc_l;
    logic [ACC_W-1:0]      acc_r;
    logic [ACC_W-1:0]      prod_l;
    logic [ACC_W-1:0]      prod_r;
    logic [ACC_W-1:0]      term_l;
    logic [ACC_W-1:0]      term_r;

    assign tick = (cnt == CNT_W'(DIV - 1));

    always_ff @(posedge clk_pixel_w or negedge system_reset_n_w) begin
        if (!system_reset_n_w) begin
            cnt             <= '0;
            bus.clk_audio_o <= 1'b0;
        end else begin
            cnt             <= tick ? '0 : cnt + CNT_W'(1);
            bus.clk_audio_o <= (cnt >= CNT_W'(DIV / 2));
        end
    end

    audio_mixer_speaker_pulse #(
        .SPEAKER_HOLD   (SPEAKER_HOLD),
        .SPEAKER_ENABLE (SPEAKER_ENABLE)
    ) u_speaker_pulse (
        .clk_pixel_w      (clk_pixel_w),
        .system_reset_n_w (system_reset_n_w),
        .tick             (tick),
        .speaker_bit      (bus.speaker_bit_i),
        .spk_on           (spk_on)
    );

    always_ff @(posedge clk_pixel_w or negedge system_reset_n_w) begin
        if (!system_reset_n_w) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (tick) next_state = SNAP;
            SNAP:    next_state = ACC;
            ACC:     if (idx == IDX_W'(NUM_SRC - 1)) next_state = SAT;
            SAT:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Gain 8 is unity: the >>3 drops the fractional bits, the left shift
    // places a full-scale source just below a quarter of the output range.
    always_comb begin
        prod_l = ACC_W'(snap_l[idx]) * ACC_W'(snap_gain[idx]);
        prod_r = ACC_W'(snap_r[idx]) * ACC_W'(snap_gain[idx]);
        term_l = (prod_l >> GAIN_SHIFT) << TERM_SHIFT;
        term_r = (prod_r >> GAIN_SHIFT) << TERM_SHIFT;
    end

    function automatic logic [OUT_WIDTH-1:0] saturate(
        input logic [ACC_W-1:0] acc,
        input logic             add_spk,
        input logic             force_zero
    );
        logic [ACC_W-1:0] sum;
        sum = acc + (add_spk ? ACC_W'(SPEAKER_LEVEL) : '0);
        if (force_zero) begin
            return '0;
        end else if (|sum[ACC_W-1:OUT_WIDTH]) begin
            return '1;
        end else begin
            return sum[OUT_WIDTH-1:0];
        end
    endfunction

    always_ff @(posedge clk_pixel_w or negedge system_reset_n_w) begin
        if (!system_reset_n_w) begin
            for (int unsigned k = 0; k < NUM_SRC; k++) begin
                snap_l[k]    <= '0;
                snap_r[k]    <= '0;
                snap_gain[k] <= '0;
            end
            snap_mute          <= 1'b0;
            snap_spk           <= 1'b0;
            idx                <= '0;
            acc_l              <= '0;
            acc_r              <= '0;
            bus.sample_l_o     <= '0;
            bus.sample_r_o     <= '0;
            bus.sample_valid_o <= 1'b0;
        end else begin
            bus.sample_valid_o <= 1'b0;
            case (state)
                SNAP: begin
                    for (int unsigned k = 0; k < NUM_SRC; k++) begin
                        snap_l[k]    <= bus.src_l_i[k*SRC_WIDTH +: SRC_WIDTH];
                        snap_r[k]    <= bus.src_r_i[k*SRC_WIDTH +: SRC_WIDTH];
                        snap_gain[k] <= bus.src_gain_i[k*GAIN_WIDTH +: GAIN_WIDTH];
                    end
                    snap_mute <= bus.mute_i;
                    snap_spk  <= spk_on;
                    idx       <= '0;
                    acc_l     <= '0;
                    acc_r     <= '0;
                end
                ACC: begin
                    acc_l <= acc_l + term_l;
                    acc_r <= acc_r + term_r;
                    idx   <= idx + IDX_W'(1);
                end
                SAT: begin
                    bus.sample_l_o     <= saturate(acc_l, snap_spk, snap_mute);
                    bus.sample_r_o     <= saturate(acc_r, snap_spk, snap_mute);
                    bus.sample_valid_o <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_audio_mixer.sv
`default_nettype none
// ============================================================================
// tb_audio_mixer : scoreboard bench for audio_mixer with directed sample vectors
// Revision 1.0
// ============================================================================
module tb_audio_mixer;
    import audio_mixer_pkg::*;

    localparam int NUM_SRC   = 2;
    localparam int SRC_WIDTH = 10;
    localparam int OUT_WIDTH = 16;
    localparam int DIV       = 612;
    localparam int SPK_HOLD  = 20;

    typedef struct {
        logic [OUT_WIDTH-1:0] l;
        logic [OUT_WIDTH-1:0] r;
    } exp_t;

    logic clk_pixel_w      = 1'b0;
    logic system_reset_n_w = 1'b0;
    int   n_checks         = 0;
    int   n_fail           = 0;
    int   cyc              = 0;
    exp_t exp_q[$];

    bit   en_cadence       = 1'b0;
    bit   have_prev        = 1'b0;
    int   prev_valid_cyc   = 0;
    bit   run_valid        = 1'b0;
    int   run_len          = 0;
    logic last_clk_audio   = 1'b0;

    always #5 clk_pixel_w = ~clk_pixel_w;
    always @(posedge clk_pixel_w) cyc <= cyc + 1;

    audio_mixer_if #(
        .NUM_SRC   (NUM_SRC),
        .SRC_WIDTH (SRC_WIDTH),
        .OUT_WIDTH (OUT_WIDTH)
    ) bus ();

    audio_mixer #(
        .PIXEL_CLK_HZ   (27_000_000),
        .AUDIO_RATE     (44_100),
        .NUM_SRC        (NUM_SRC),
        .SRC_WIDTH      (SRC_WIDTH),
        .OUT_WIDTH      (OUT_WIDTH),
        .SPEAKER_ENABLE (1),
        .SPEAKER_HOLD   (SPK_HOLD),
        .SPEAKER_LEVEL  (32'h2000)
    ) dut (
        .clk_pixel_w      (clk_pixel_w),
        .system_reset_n_w (system_reset_n_w),
        .bus              (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
        end
    endtask

    task automatic set_src(input int k, input logic [9:0] l, input logic [9:0] r, input logic [3:0] g);
        bus.src_l_i[k*SRC_WIDTH +: SRC_WIDTH]      = l;
        bus.src_r_i[k*SRC_WIDTH +: SRC_WIDTH]      = r;
        bus.src_gain_i[k*GAIN_WIDTH +: GAIN_WIDTH] = g;
    endtask

    task automatic expect_sample(input logic [15:0] l, input logic [15:0] r);
        exp_t e;
        e.l = l;
        e.r = r;
        exp_q.push_back(e);
    endtask

    task automatic wait_valid();
        int n = 0;
        do begin
            @(negedge clk_pixel_w);
            n++;
        end while (!bus.sample_valid_o && n < DIV + 10);
        if (!bus.sample_valid_o) begin
            n_checks++;
            n_fail++;
            $display("FAIL valid_timeout: no sample_valid_o within %0d cycles", n);
        end
    endtask

    task automatic step(input logic [15:0] l, input logic [15:0] r);
        expect_sample(l, r);
        wait_valid();
    endtask

    // Monitor: pops the scoreboard on every strobe and watches the cadence
    initial begin
        forever begin
            exp_t e;
            @(negedge clk_pixel_w);
            if (!system_reset_n_w) begin
                have_prev = 1'b0;
                run_valid = 1'b0;
            end else begin
                if (bus.sample_valid_o) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_sample: got L=0x%0h R=0x%0h, expected none",
                                 bus.sample_l_o, bus.sample_r_o);
                    end else begin
                        e = exp_q.pop_front();
                        check("sample_l", 32'(bus.sample_l_o), 32'(e.l));
                        check("sample_r", 32'(bus.sample_r_o), 32'(e.r));
                    end
                    if (have_prev) check("valid_interval", cyc - prev_valid_cyc, DIV);
                    have_prev      = 1'b1;
                    prev_valid_cyc = cyc;
                end
                if (en_cadence) begin
                    if (bus.clk_audio_o != last_clk_audio) begin
                        if (run_valid)
                            check(bus.clk_audio_o ? "clk_audio_low_len" : "clk_audio_high_len",
                                  run_len, DIV / 2);
                        if (bus.clk_audio_o && have_prev) begin
                            n_checks++;
                            if (cyc - prev_valid_cyc < 300) begin
                                n_fail++;
                                $display("FAIL clk_audio_rise_gap: got %0d cycles, expected >= 300",
                                         cyc - prev_valid_cyc);
                            end
                        end
                        run_valid = 1'b1;
                        run_len   = 1;
                    end else begin
                        run_len++;
                    end
                end else begin
                    run_valid = 1'b0;
                end
            end
            last_clk_audio = bus.clk_audio_o;
        end
    end

    initial begin
        int rel;
        bus.speaker_bit_i = 1'b0;
        bus.src_l_i       = '0;
        bus.src_r_i       = '0;
        bus.src_gain_i    = '0;
        bus.mute_i        = 1'b0;

        repeat (3) @(negedge clk_pixel_w);
        check("reset_clk_audio", 32'(bus.clk_audio_o), 0);
        check("reset_sample_l", 32'(bus.sample_l_o), 0);
        check("reset_sample_r", 32'(bus.sample_r_o), 0);
        check("reset_valid", 32'(bus.sample_valid_o), 0);

        // Cadence with silent sources
        system_reset_n_w = 1'b1;
        rel              = cyc;
        en_cadence       = 1'b1;
        step(16'h0000, 16'h0000);
        check("first_valid_latency", cyc - rel, DIV + 4);
        repeat (9) step(16'h0000, 16'h0000);
        en_cadence = 1'b0;

        // Unity gain on source 0, source 1 switched off by gain 0
        set_src(0, 10'h3FF, 10'h3FF, 4'd8);
        set_src(1, 10'h3FF, 10'h3FF, 4'd0);
        step(16'h3FF0, 16'h3FF0);

        // Mixed gains, distinct L/R
        set_src(0, 10'h155, 10'h2AA, 4'd5);
        set_src(1, 10'h0F0, 10'h00F, 4'd12);
        step(16'h23D0, 16'h1C00);

        // Saturation, then speaker pushes it over full scale
        set_src(0, 10'h3FF, 10'h3FF, 4'd15);
        set_src(1, 10'h3FF, 10'h3FF, 4'd15);
        step(16'hEFC0, 16'hEFC0);
        bus.speaker_bit_i = 1'b1;
        step(16'hFFFF, 16'hFFFF);

        // Remainder of the speaker hold on silent sources
        set_src(0, 10'h000, 10'h000, 4'd15);
        set_src(1, 10'h000, 10'h000, 4'd15);
        repeat (SPK_HOLD - 1) step(16'h2000, 16'h2000);
        step(16'h0000, 16'h0000);

        // Falling toggle reloads the counter but the pulse stays off
        bus.speaker_bit_i = 1'b0;
        step(16'h0000, 16'h0000);
        step(16'h0000, 16'h0000);

        // Mute keeps the strobe going with zero samples
        set_src(0, 10'h3FF, 10'h3FF, 4'd15);
        set_src(1, 10'h3FF, 10'h3FF, 4'd15);
        bus.mute_i = 1'b1;
        step(16'h0000, 16'h0000);
        step(16'h0000, 16'h0000);
        bus.mute_i = 1'b0;
        step(16'hEFC0, 16'hEFC0);

        // Input change while accumulating only shows in the following sample
        set_src(0, 10'h100, 10'h100, 4'd8);
        set_src(1, 10'h000, 10'h000, 4'd0);
        step(16'h1000, 16'h1000);
        expect_sample(16'h1000, 16'h1000);
        repeat (609) @(posedge clk_pixel_w);
        #1;
        set_src(0, 10'h200, 10'h200, 4'd8);
        wait_valid();
        step(16'h2000, 16'h2000);

        // Reset in the middle of accumulation
        repeat (609) @(posedge clk_pixel_w);
        #1;
        system_reset_n_w = 1'b0;
        #1;
        check("midreset_sample_l", 32'(bus.sample_l_o), 0);
        check("midreset_sample_r", 32'(bus.sample_r_o), 0);
        check("midreset_valid", 32'(bus.sample_valid_o), 0);
        repeat (3) @(negedge clk_pixel_w);
        system_reset_n_w = 1'b1;
        rel              = cyc;
        step(16'h2000, 16'h2000);
        check("post_reset_latency", cyc - rel, DIV + 4);

        repeat (5) @(negedge clk_pixel_w);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
